// File: rtl/idct_pkg.sv
// Shared defaults and bank-state encoding for the IDCT4 transpose stage.
package idct_pkg;
  localparam int unsigned WIDTH_Y_DEF = 22;
  localparam int unsigned WIDTH_X_DEF = 16;
  localparam int unsigned SHIFT_DEF   = 7;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } bank_state_t;
endpackage

// File: rtl/idct4_rnd_clip.sv
// One lane of first-pass scaling: round-half-up right shift, then saturate to width_x.
module idct4_rnd_clip
  import idct_pkg::*;
#(
  parameter int unsigned width_y = WIDTH_Y_DEF,
  parameter int unsigned width_x = WIDTH_X_DEF,
  parameter int unsigned SHIFT   = SHIFT_DEF
) (
  input  logic signed [width_y-1:0] i_d,
  output logic signed [width_x-1:0] o_q,
  output logic                      o_clip
);
  localparam logic signed [width_y:0] RND  = {{width_y{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [width_y:0] MAXV = {{(width_y-width_x+2){1'b0}}, {(width_x-1){1'b1}}};
  localparam logic signed [width_y:0] MINV = {{(width_y-width_x+2){1'b1}}, {(width_x-1){1'b0}}};

  logic signed [width_y:0] w_sum;
  logic signed [width_y:0] w_r;

  // One guard bit keeps the rounding add from wrapping at the positive rail.
  assign w_sum = {i_d[width_y-1], i_d} + RND;
  assign w_r   = w_sum >>> SHIFT;

  always_comb begin
    o_q    = w_r[width_x-1:0];
    o_clip = 1'b0;
    if (w_r > MAXV) begin
      o_q    = MAXV[width_x-1:0];
      o_clip = 1'b1;
    end else if (w_r < MINV) begin
      o_q    = MINV[width_x-1:0];
      o_clip = 1'b1;
    end
  end
endmodule

// File: rtl/idct4_transpose.sv
// Rounds/clips IDCT4 first-pass rows into a 4x4 buffer and re-emits it column by column.
// Define IDCT4_TRANSPOSE_PINGPONG_EN for two banks (one fills while the other drains).
module idct4_transpose
  import idct_pkg::*;
#(
  parameter int unsigned width_y = WIDTH_Y_DEF,
  parameter int unsigned width_x = WIDTH_X_DEF,
  parameter int unsigned SHIFT   = SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [width_y-1:0] d0,
  input  logic signed [width_y-1:0] d1,
  input  logic signed [width_y-1:0] d2,
  input  logic signed [width_y-1:0] d3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [width_x-1:0] q0,
  output logic signed [width_x-1:0] q1,
  output logic signed [width_x-1:0] q2,
  output logic signed [width_x-1:0] q3,
  output logic                      sat
);
`ifdef IDCT4_TRANSPOSE_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  // Two bank slots always exist; with PP=0 both pointers stay on bank 0 and bank 1 is dead logic.
  bank_state_t               r_state     [2];
  bank_state_t               w_state_nxt [2];
  logic                      r_wr_bank;
  logic                      r_rd_bank;
  logic [1:0]                r_wr_row;
  logic [1:0]                r_rd_col;
  logic                      r_sat;
  logic signed [width_x-1:0] r_buf [2][4][4];
  logic signed [width_y-1:0] w_d   [4];
  logic signed [width_x-1:0] w_q   [4];
  logic [3:0]                w_clip;
  logic                      w_in_hs;
  logic                      w_out_hs;

  assign w_d[0] = d0;
  assign w_d[1] = d1;
  assign w_d[2] = d2;
  assign w_d[3] = d3;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    idct4_rnd_clip #(.width_y(width_y), .width_x(width_x), .SHIFT(SHIFT)) u_rnd_clip (
      .i_d   (w_d[g]),
      .o_q   (w_q[g]),
      .o_clip(w_clip[g])
    );
  end

  assign in_ready  = (r_state[r_wr_bank] == FILL);
  assign out_valid = (r_state[r_rd_bank] == DRAIN);
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign sat       = r_sat;

  assign q0 = out_valid ? r_buf[r_rd_bank][0][r_rd_col] : '0;
  assign q1 = out_valid ? r_buf[r_rd_bank][1][r_rd_col] : '0;
  assign q2 = out_valid ? r_buf[r_rd_bank][2][r_rd_col] : '0;
  assign q3 = out_valid ? r_buf[r_rd_bank][3][r_rd_col] : '0;

  // A handshake implies the addressed bank is in the matching state, so no state test is needed.
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    if (w_in_hs && r_wr_row == 2'd3)
      w_state_nxt[r_wr_bank] = DRAIN;
    if (w_out_hs && r_rd_col == 2'd3)
      w_state_nxt[r_rd_bank] = FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0] <= FILL;
      r_state[1] <= FILL;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_row   <= '0;
      r_rd_col   <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      r_sat      <= w_in_hs & (|w_clip);
      if (w_in_hs) begin
        r_wr_row <= r_wr_row + 2'd1;
        if (r_wr_row == 2'd3)
          r_wr_bank <= r_wr_bank ^ PP;
      end
      if (w_out_hs) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (r_rd_col == 2'd3)
          r_rd_bank <= r_rd_bank ^ PP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_buf[r_wr_bank][r_wr_row][0] <= w_q[0];
      r_buf[r_wr_bank][r_wr_row][1] <= w_q[1];
      r_buf[r_wr_bank][r_wr_row][2] <= w_q[2];
      r_buf[r_wr_bank][r_wr_row][3] <= w_q[3];
    end
  end
endmodule

// File: tb/tb_idct4_transpose.sv
// Self-checking bench for idct4_transpose: SHIFT=7 and SHIFT=5 instances share stimulus,
// checked against an arithmetic row/column model. Honours IDCT4_TRANSPOSE_PINGPONG_EN.
module tb_idct4_transpose;
`ifdef IDCT4_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int WY = 22;
  localparam int WX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [WY-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic in_ready, out_valid, sat, in_ready5, out_valid5, sat5;
  logic signed [WX-1:0] q0, q1, q2, q3, p0, p1, p2, p3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  longint raw [4][4];
  int nrow = 0;
  longint expq7[$];
  longint expq5[$];
  bit exp_sat7 = 1'b0, exp_sat5 = 1'b0;
  bit hs_in, hs_out, s_ir;
  bit s_sat7, s_sat5;
  logic signed [63:0] s_q7 [4];
  logic signed [63:0] s_q5 [4];

  idct4_transpose #(.width_y(WY), .width_x(WX), .SHIFT(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(out_valid), .out_ready(out_ready),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .sat(sat)
  );

  idct4_transpose #(.width_y(WY), .width_x(WX), .SHIFT(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(out_valid5), .out_ready(out_ready),
    .q0(p0), .q1(p1), .q2(p2), .q3(p3), .sat(sat5)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed no handshake expected handshake within bound", tag);
  endtask

  // floor((d + 2^(s-1)) / 2^s) done with ordinary integer division
  function automatic longint rnd(input longint d, input int s);
    longint p = longint'(1) << s;
    longint t = d + p / 2;
    if (t >= 0) return t / p;
    return -((-t + p - 1) / p);
  endfunction

  function automatic longint clipv(input longint r);
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  function automatic logic signed [WY-1:0] rdat();
    logic [31:0] r = $urandom;
    logic signed [WY-1:0] v = r[WY-1:0];
    if ($urandom_range(0, 2) != 0) v = {{8{r[13]}}, r[13:0]};
    return v;
  endfunction

  // One clock: sample and check at negedge, update model, return at posedge+1.
  task automatic step();
    int pend;
    bit exp_ir, exp_ov;
    @(negedge clk);
    cyc++;
    pend   = expq7.size() / 4;
    exp_ir = (pend <= 4 * (NB - 1));
    exp_ov = (pend > 0);
    check("in_ready", in_ready, exp_ir);
    check("in_ready5", in_ready5, exp_ir);
    check("out_valid", out_valid, exp_ov);
    check("out_valid5", out_valid5, exp_ov);
    check("sat", sat, exp_sat7);
    check("sat5", sat5, exp_sat5);
    s_ir = in_ready; s_sat7 = sat; s_sat5 = sat5;
    s_q7[0] = q0; s_q7[1] = q1; s_q7[2] = q2; s_q7[3] = q3;
    s_q5[0] = p0; s_q5[1] = p1; s_q5[2] = p2; s_q5[3] = p3;
    if (exp_ov) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("col7_q%0d", i), s_q7[i], expq7[i]);
        check($sformatf("col5_q%0d", i), s_q5[i], expq5[i]);
      end
    end
    hs_out = exp_ov && out_ready;
    hs_in  = exp_ir && in_valid;
    exp_sat7 = 1'b0;
    exp_sat5 = 1'b0;
    if (hs_out) begin
      repeat (4) begin
        void'(expq7.pop_front());
        void'(expq5.pop_front());
      end
    end
    if (hs_in) begin
      raw[nrow][0] = d0; raw[nrow][1] = d1; raw[nrow][2] = d2; raw[nrow][3] = d3;
      for (int i = 0; i < 4; i++) begin
        if (clipv(rnd(raw[nrow][i], 7)) != rnd(raw[nrow][i], 7)) exp_sat7 = 1'b1;
        if (clipv(rnd(raw[nrow][i], 5)) != rnd(raw[nrow][i], 5)) exp_sat5 = 1'b1;
      end
      nrow++;
      if (nrow == 4) begin
        for (int j = 0; j < 4; j++)
          for (int i = 0; i < 4; i++) begin
            expq7.push_back(clipv(rnd(raw[i][j], 7)));
            expq5.push_back(clipv(rnd(raw[i][j], 5)));
          end
        nrow = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input longint a, input longint b, input longint c, input longint e);
    int k = 0;
    d0 = a[WY-1:0]; d1 = b[WY-1:0]; d2 = c[WY-1:0]; d3 = e[WY-1:0];
    in_valid = 1'b1;
    hs_in = 1'b0;
    while (!hs_in && k < 40) begin
      step();
      k++;
    end
    if (!hs_in) tmo("send_row");
    in_valid = 1'b0;
  endtask

  task automatic drain_chk(input string tag, input bit use5, input longint e[16]);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      int k = 0;
      hs_out = 1'b0;
      while (!hs_out && k < 20) begin
        step();
        k++;
      end
      if (!hs_out) begin
        tmo(tag);
        return;
      end
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_c%0d_q%0d", tag, j, i), use5 ? s_q5[i] : s_q7[i], e[j*4+i]);
    end
  endtask

  task automatic drain_all(input string tag);
    int k = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (expq7.size() != 0 && k < 80) begin
      step();
      k++;
    end
    if (expq7.size() != 0) tmo(tag);
  endtask

  initial begin
    longint e[16];
    int rows_sent, cols, first, last, ir_low;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_q0", q0, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;
    step();

    // rounding corners at SHIFT=7
    send_row(6400, -65, 63, -64);
    repeat (3) send_row(0, 0, 0, 0);
    e = '{50, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drain_chk("round", 1'b0, e);

    // transpose of a pre-scaled 1..16 block
    for (int k = 0; k < 4; k++)
      send_row(128 * (4*k+1), 128 * (4*k+2), 128 * (4*k+3), 128 * (4*k+4));
    e = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
    drain_chk("xpose", 1'b0, e);

    // clipping on the SHIFT=5 instance
    send_row(2097151, -2097152, 0, 0);
    step();
    check("clip_sat5", s_sat5, 1);
    check("clip_sat7", s_sat7, 0);
    repeat (3) send_row(0, 0, 0, 0);
    e = '{32767, 0, 0, 0, -32768, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drain_chk("clip", 1'b1, e);

    // backpressure mid-drain
    for (int k = 0; k < 4; k++) send_row(rdat(), rdat(), rdat(), rdat());
    out_ready = 1'b1;
    hs_out = 1'b0;
    for (int k = 0; k < 20 && !hs_out; k++) step();
    out_ready = 1'b0;
    repeat (5) step();
    check("bp_pending_cols", expq7.size() / 4, 3);
    drain_all("bp_drain");

    // reset after two rows
    send_row(rdat(), rdat(), rdat(), rdat());
    send_row(rdat(), rdat(), rdat(), rdat());
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_q0", q0, 0);
    nrow = 0;
    expq7.delete();
    expq5.delete();
    exp_sat7 = 1'b0;
    exp_sat5 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      send_row(128 * (4*k+17), 128 * (4*k+18), 128 * (4*k+19), 128 * (4*k+20));
    e = '{17, 21, 25, 29, 18, 22, 26, 30, 19, 23, 27, 31, 20, 24, 28, 32};
    drain_chk("post_rst", 1'b0, e);

    // three back-to-back blocks under continuous valid/ready
    rows_sent = 0; cols = 0; first = -1; last = -1; ir_low = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 80 && cols < 12; k++) begin
      d0 = rdat(); d1 = rdat(); d2 = rdat(); d3 = rdat();
      in_valid = (rows_sent < 12);
      step();
      if (hs_in) rows_sent++;
      if (rows_sent < 12 && !s_ir) ir_low++;
      if (hs_out) begin
        cols++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    in_valid = 1'b0;
    check("stream_cols", cols, 12);
`ifdef IDCT4_TRANSPOSE_PINGPONG_EN
    check("stream_span", last - first, 11);
    check("stream_in_ready_low", ir_low, 0);
`endif

    // random valid/ready/data
    for (int k = 0; k < 400; k++) begin
      d0 = rdat(); d1 = rdat(); d2 = rdat(); d3 = rdat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain_all("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
